xmit_pkt_gen: RTL

Synthesizable, parametrised frame-stimulus generator for the transmit path. It drives the receive-side interface of `xmitTop`: data byte, data-valid, control block, control-valid and high-priority. It emits a programmable number of back-to-back frames, each made of a header pattern, a body and a trailer pattern, with optional inter-frame gap, backpressure and per-frame priority modes. It runs in the `clk_sys` domain and replaces hand-sequenced bench stimulus in system-level and on-chip loopback tests.

---
 rtl/xmit_pkt_gen_if.sv | 41 ++++
 rtl/xmit_pkt_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xmit_pkt_gen_if.sv
// ============================================================================
// Module      : xmit_pkt_gen_if
// Description : Control and frame-stream bundle between the frame-stimulus
//               generator (master) and its controller/consumer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xmit_pkt_gen_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12,
  parameter int CNT_W  = 8
);
  logic                 start;
  logic [LEN_W-1:0]     pkt_len;
  logic [CNT_W-1:0]     num_pkts;
  logic [1:0]           prio_mode;
  logic                 ready;
  logic [DATA_W-1:0]    f_data_out;
  logic                 f_data_valid;
  logic [2*LEN_W-1:0]   f_ctrl_out;
  logic                 f_ctrl_valid;
  logic                 f_hi_priority;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     pkt_cnt;

  modport master (
    input  start, pkt_len, num_pkts, prio_mode, ready,
    output f_data_out, f_data_valid, f_ctrl_out, f_ctrl_valid, f_hi_priority,
           busy, done, pkt_cnt
  );

  modport slave (
    output start, pkt_len, num_pkts, prio_mode, ready,
    input  f_data_out, f_data_valid, f_ctrl_out, f_ctrl_valid, f_hi_priority,
           busy, done, pkt_cnt
  );
endinterface

`default_nettype wire

// File: rtl/xmit_pkt_gen.sv
// ============================================================================
// Module      : xmit_pkt_gen
// Description : Frame-stimulus generator for the transmit path. Emits
//               num_pkts frames of header / body / trailer beats with
//               optional inter-frame gap, backpressure and priority modes.
//               Optional feature macro: PKTGEN_PAYLOAD_CNT_EN (body beats
//               carry an incrementing byte counter instead of BODY_PAT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xmit_pkt_gen #(
  parameter int                DATA_W   = 8,
  parameter int                LEN_W    = 12,
  parameter int                CNT_W    = 8,
  parameter int                HEAD_LEN = 4,
  parameter int                TAIL_LEN = 4,
  parameter logic [DATA_W-1:0] HEAD_PAT = 8'hFF,
  parameter logic [DATA_W-1:0] BODY_PAT = 8'h00,
  parameter int                IPG      = 0
) (
  input  wire logic          clk_sys,
  input  wire logic          reset,
  xmit_pkt_gen_if.master     bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_BODY = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [LEN_W-1:0] c_min_len   = LEN_W'(HEAD_LEN + TAIL_LEN);
  localparam logic [LEN_W-1:0] c_head_last = LEN_W'(HEAD_LEN - 1);
  localparam logic [LEN_W-1:0] c_tail_last = LEN_W'(TAIL_LEN - 1);
  localparam logic [LEN_W-1:0] c_gap_last  = LEN_W'((IPG > 0) ? IPG - 1 : 0);

  // The state/beat/frame registers name the beat to be presented next; the
  // output registers hold the beat currently presented. Both advance together
  // whenever the presented beat is consumed or nothing busy is presented.
  logic [2:0]          r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_beat, w_beat_nxt;
  logic [CNT_W-1:0]    r_frame, w_frame_nxt;
  logic [LEN_W-1:0]    r_eff_len, r_body_len, w_eff_in;
  logic [CNT_W-1:0]    r_num;
  logic [1:0]          r_prio;

  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_valid, w_valid;
  logic [2*LEN_W-1:0]  r_ctrl, w_ctrl;
  logic                r_ctrl_valid, w_ctrl_valid;
  logic                r_hi, w_hi, w_frame_hi;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_last_tail, w_last_tail;
  logic [CNT_W-1:0]    r_pkt_cnt;

  logic                w_adv, w_accept, w_last_frame;

  assign w_adv        = bus.ready | ~r_busy;
  assign w_accept     = (r_state == S_IDLE) & bus.start;
  assign w_eff_in     = (bus.pkt_len < c_min_len) ? c_min_len : bus.pkt_len;
  assign w_last_frame = (r_frame == (r_num - CNT_W'(1)));

`ifdef PKTGEN_PAYLOAD_CNT_EN
  logic [DATA_W-1:0]   r_pay;

  // Payload counter: restarts on each frame's first body beat, steps per body beat produced.
  always_ff @(posedge clk_sys) begin
    if (reset)      r_pay <= '0;
    else if (w_adv) r_pay <= (r_state == S_BODY) ? r_pay + DATA_W'(1) : '0;
  end
`endif

  // Run parameters captured once per accepted start; immune to later input changes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_eff_len  <= '0;
      r_body_len <= '0;
      r_num      <= '0;
      r_prio     <= '0;
    end else if (w_accept) begin
      r_eff_len  <= w_eff_in;
      r_body_len <= w_eff_in - c_min_len;
      r_num      <= bus.num_pkts;
      r_prio     <= bus.prio_mode;
    end
  end

  // State register with beat and frame position.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_frame <= '0;
    end else if (w_adv) begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // Next-state and position sequencing through header, body, trailer and gap.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat + LEN_W'(1);
    w_frame_nxt = r_frame;
    case (r_state)
      S_IDLE: begin
        w_beat_nxt  = '0;
        w_frame_nxt = '0;
        if (bus.start) w_state_nxt = (bus.num_pkts == '0) ? S_DONE : S_HEAD;
      end
      S_HEAD: if (r_beat == c_head_last) begin
        w_beat_nxt  = '0;
        w_state_nxt = (r_body_len == '0) ? S_TAIL : S_BODY;
      end
      S_BODY: if (r_beat == (r_body_len - LEN_W'(1))) begin
        w_beat_nxt  = '0;
        w_state_nxt = S_TAIL;
      end
      S_TAIL: if (r_beat == c_tail_last) begin
        w_beat_nxt = '0;
        if (IPG > 0) begin
          w_state_nxt = S_GAP;
        end else if (w_last_frame) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_HEAD;
          w_frame_nxt = r_frame + CNT_W'(1);
        end
      end
      S_GAP: if (r_beat == c_gap_last) begin
        w_beat_nxt = '0;
        if (w_last_frame) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_HEAD;
          w_frame_nxt = r_frame + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_beat_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_beat_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-frame priority from the latched mode and the frame index.
  always_comb begin
    case (r_prio)
      2'b00:   w_frame_hi = 1'b0;
      2'b01:   w_frame_hi = 1'b1;
      2'b10:   w_frame_hi = ~r_frame[0];
      default: w_frame_hi = (r_frame[1:0] == 2'b00);
    endcase
  end

  // Output decode of the beat at the current position.
  always_comb begin
    w_data       = '0;
    w_valid      = 1'b0;
    w_ctrl       = '0;
    w_ctrl_valid = 1'b0;
    w_hi         = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_last_tail  = 1'b0;
    case (r_state)
      S_HEAD: begin
        w_data  = HEAD_PAT;
        w_valid = 1'b1;
        w_hi    = w_frame_hi;
        w_busy  = 1'b1;
        if (r_beat == '0) begin
          w_ctrl_valid = 1'b1;
          w_ctrl       = {r_eff_len, r_eff_len};
        end
      end
      S_BODY: begin
`ifdef PKTGEN_PAYLOAD_CNT_EN
        w_data  = r_pay;
`else
        w_data  = BODY_PAT;
`endif
        w_valid = 1'b1;
        w_hi    = w_frame_hi;
        w_busy  = 1'b1;
      end
      S_TAIL: begin
        w_data      = HEAD_PAT;
        w_valid     = 1'b1;
        w_hi        = w_frame_hi;
        w_busy      = 1'b1;
        w_last_tail = (r_beat == c_tail_last);
      end
      S_GAP:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Output registers: load the next beat when the presented one is consumed.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_ctrl_valid <= 1'b0;
      r_hi         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_last_tail  <= 1'b0;
    end else if (w_adv) begin
      r_data       <= w_data;
      r_valid      <= w_valid;
      r_ctrl       <= w_ctrl;
      r_ctrl_valid <= w_ctrl_valid;
      r_hi         <= w_hi;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_last_tail  <= w_last_tail;
    end
  end

  // Completed-frame counter: cleared on start, stepped when a last trailer beat transfers.
  always_ff @(posedge clk_sys) begin
    if (reset)                                r_pkt_cnt <= '0;
    else if (w_accept)                        r_pkt_cnt <= '0;
    else if (r_valid & bus.ready & r_last_tail) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
  end

  assign bus.f_data_out    = r_data;
  assign bus.f_data_valid  = r_valid;
  assign bus.f_ctrl_out    = r_ctrl;
  assign bus.f_ctrl_valid  = r_ctrl_valid;
  assign bus.f_hi_priority = r_hi;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pkt_cnt       = r_pkt_cnt;

endmodule

`default_nettype wire
